// File: rtl/router_port_credit_buffer_if.sv
// Channel, buffer and credit bundle shared by the router port stage and the core.
// slave: the credit buffer side; master: the fabric/core driving it.
interface router_port_credit_buffer_if #(
    parameter int NUM_PORTS  = 5,
    parameter int FLIT_WIDTH = 67
);
    localparam int CHW = FLIT_WIDTH + 1;

    logic [NUM_PORTS*CHW-1:0]        channel_in_ip;
    logic [NUM_PORTS-1:0]            flow_ctrl_out_ip;
    logic [NUM_PORTS*FLIT_WIDTH-1:0] buf_flit;
    logic [NUM_PORTS-1:0]            buf_valid;
    logic [NUM_PORTS-1:0]            buf_ready;
    logic [NUM_PORTS*FLIT_WIDTH-1:0] core_flit;
    logic [NUM_PORTS-1:0]            core_valid;
    logic [NUM_PORTS-1:0]            core_ready;
    logic [NUM_PORTS*CHW-1:0]        channel_out_op;
    logic [NUM_PORTS-1:0]            flow_ctrl_in_op;
    logic                            error;
    logic [2*NUM_PORTS-1:0]          error_status;

    modport slave (
        input  channel_in_ip, buf_ready, core_flit,
        input  core_valid, flow_ctrl_in_op,
        output flow_ctrl_out_ip, buf_flit, buf_valid,
        output core_ready, channel_out_op,
        output error, error_status
    );

    modport master (
        output channel_in_ip, buf_ready, core_flit,
        output core_valid, flow_ctrl_in_op,
        input  flow_ctrl_out_ip, buf_flit, buf_valid,
        input  core_ready, channel_out_op,
        input  error, error_status
    );
endinterface

// File: rtl/router_port_credit_buffer.sv
// Per-port router boundary: inbound FWFT FIFOs with credit return, outbound
// credit counters with a registered channel, sticky per-cause error flags.
// Ports: clk, reset (sync, active-high), bus (router_port_credit_buffer_if.slave).
module router_port_credit_buffer #(
    parameter int NUM_PORTS  = 5,
    parameter int FLIT_WIDTH = 67,
    parameter int DEPTH      = 4,
    parameter int CREDITS    = 4
) (
    input  logic clk,
    input  logic reset,
    router_port_credit_buffer_if.slave bus
);
    localparam int CHW = FLIT_WIDTH + 1;
    localparam int AW  = $clog2(DEPTH);
    localparam int CRW = $clog2(CREDITS + 1);
    localparam logic [AW:0]    FULL = (AW + 1)'(DEPTH);
    localparam logic [CRW-1:0] CMAX = CRW'(CREDITS);

    logic [FLIT_WIDTH-1:0] mem_q [NUM_PORTS][DEPTH];
    logic [AW-1:0]  wp_q  [NUM_PORTS];
    logic [AW-1:0]  wp_d  [NUM_PORTS];
    logic [AW-1:0]  rp_q  [NUM_PORTS];
    logic [AW-1:0]  rp_d  [NUM_PORTS];
    logic [AW:0]    cnt_q [NUM_PORTS];
    logic [AW:0]    cnt_d [NUM_PORTS];
    logic [CRW-1:0] crd_q [NUM_PORTS];
    logic [CRW-1:0] crd_d [NUM_PORTS];
    logic [FLIT_WIDTH-1:0] od_q [NUM_PORTS];
    logic [FLIT_WIDTH-1:0] od_d [NUM_PORTS];
    logic [NUM_PORTS-1:0]  ov_q, ov_d;
    logic [NUM_PORTS-1:0]  fco_q, fco_d;
    logic [2*NUM_PORTS-1:0] err_q, err_d;
    logic                   error_q, error_d;

    logic [NUM_PORTS-1:0] pop_w, push_w, drop_w;
    logic [NUM_PORTS-1:0] send_w, covf_w;

    logic [NUM_PORTS*FLIT_WIDTH-1:0] buf_flit_w;
    logic [NUM_PORTS-1:0]            buf_valid_w;
    logic [NUM_PORTS-1:0]            core_ready_w;
    logic [NUM_PORTS*CHW-1:0]        chan_out_w;

    // Handshake decode; a full FIFO still accepts when its head leaves.
    always_comb begin
        pop_w  = '0;
        push_w = '0;
        drop_w = '0;
        send_w = '0;
        covf_w = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            pop_w[p]  = (cnt_q[p] != '0) && bus.buf_ready[p];
            push_w[p] = bus.channel_in_ip[p*CHW+FLIT_WIDTH] &&
                        ((cnt_q[p] != FULL) || pop_w[p]);
            drop_w[p] = bus.channel_in_ip[p*CHW+FLIT_WIDTH] &&
                        (cnt_q[p] == FULL) && !pop_w[p];
            send_w[p] = bus.core_valid[p] && (crd_q[p] != '0);
            covf_w[p] = bus.flow_ctrl_in_op[p] && !send_w[p] &&
                        (crd_q[p] == CMAX);
        end
    end

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        crd_d = crd_q;
        od_d  = od_q;
        ov_d  = send_w;
        fco_d = pop_w;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (push_w[p]) wp_d[p] = wp_q[p] + AW'(1);
            if (pop_w[p])  rp_d[p] = rp_q[p] + AW'(1);
            cnt_d[p] = cnt_q[p] + {{AW{1'b0}}, push_w[p]}
                                - {{AW{1'b0}}, pop_w[p]};
            if (send_w[p]) begin
                od_d[p] = bus.core_flit[p*FLIT_WIDTH +: FLIT_WIDTH];
            end
            unique case ({send_w[p], bus.flow_ctrl_in_op[p]})
                2'b10:   crd_d[p] = crd_q[p] - CRW'(1);
                2'b01:   crd_d[p] = covf_w[p] ? crd_q[p]
                                              : crd_q[p] + CRW'(1);
                default: crd_d[p] = crd_q[p];
            endcase
        end
        err_d   = err_q | {covf_w, drop_w};
        error_d = |err_d;
    end

    // Storage is not reset; clearing the pointers discards its contents.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (push_w[p]) begin
                mem_q[p][wp_q[p]] <=
                    bus.channel_in_ip[p*CHW +: FLIT_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                wp_q[p]  <= '0;
                rp_q[p]  <= '0;
                cnt_q[p] <= '0;
                crd_q[p] <= CMAX;
                od_q[p]  <= '0;
            end
            ov_q    <= '0;
            fco_q   <= '0;
            err_q   <= '0;
            error_q <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
            crd_q   <= crd_d;
            od_q    <= od_d;
            ov_q    <= ov_d;
            fco_q   <= fco_d;
            err_q   <= err_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        buf_flit_w   = '0;
        buf_valid_w  = '0;
        core_ready_w = '0;
        chan_out_w   = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            buf_flit_w[p*FLIT_WIDTH +: FLIT_WIDTH] = mem_q[p][rp_q[p]];
            buf_valid_w[p]  = cnt_q[p] != '0;
            core_ready_w[p] = crd_q[p] != '0;
            chan_out_w[p*CHW +: CHW] = {ov_q[p], od_q[p]};
        end
    end

    assign bus.buf_flit         = buf_flit_w;
    assign bus.buf_valid        = buf_valid_w;
    assign bus.core_ready       = core_ready_w;
    assign bus.channel_out_op   = chan_out_w;
    assign bus.flow_ctrl_out_ip = fco_q;
    assign bus.error_status     = err_q;
    assign bus.error            = error_q;
endmodule

// File: tb/tb_router_port_credit_buffer.sv
// Bench for router_port_credit_buffer: queue scoreboard per input port,
// credit model per output port, table of credit vectors on port 1.
module tb_router_port_credit_buffer;
    localparam int NP = 5;
    localparam int FW = 67;
    localparam int CH = FW + 1;
    localparam int DEPTH = 4;
    localparam int CREDITS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    router_port_credit_buffer_if #(.NUM_PORTS(NP), .FLIT_WIDTH(FW)) bus();

    router_port_credit_buffer #(
        .NUM_PORTS(NP), .FLIT_WIDTH(FW),
        .DEPTH(DEPTH), .CREDITS(CREDITS)
    ) dut (
        .clk(clk),
        .reset(rst),
        .bus(bus)
    );

    typedef struct {
        logic cv;
        logic fci;
        logic rdy;
        logic ov;
    } vec_t;

    vec_t tbl [12];

    int checks = 0;
    int failures = 0;

    logic [FW-1:0] sbq [NP][$];
    int mcrd [NP];
    logic [2*NP-1:0] merr = '0;
    logic [NP*CH-1:0] mout = '0;

    task automatic chk(string nm, logic [511:0] act, logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        logic [NP-1:0] efco;
        logic [NP-1:0] ebv;
        logic [NP-1:0] erdy;
        logic pop;
        logic snd;
        int sz;
        efco = '0;
        if (rst) begin
            for (int p = 0; p < NP; p++) begin
                sbq[p].delete();
                mcrd[p] = CREDITS;
            end
            merr = '0;
            mout = '0;
        end else begin
            for (int p = 0; p < NP; p++) begin
                sz  = sbq[p].size();
                pop = (sz != 0) && bus.buf_ready[p];
                if (pop) begin
                    chk($sformatf("flit_p%0d", p),
                        512'(bus.buf_flit[p*FW +: FW]),
                        512'(sbq[p][0]));
                    void'(sbq[p].pop_front());
                    efco[p] = 1'b1;
                end
                if (bus.channel_in_ip[p*CH+FW]) begin
                    if (sz < DEPTH || pop)
                        sbq[p].push_back(bus.channel_in_ip[p*CH +: FW]);
                    else
                        merr[p] = 1'b1;
                end
                snd = bus.core_valid[p] && (mcrd[p] != 0);
                mout[p*CH+FW] = snd;
                if (snd) mout[p*CH +: FW] = bus.core_flit[p*FW +: FW];
                if (bus.flow_ctrl_in_op[p] && !snd) begin
                    if (mcrd[p] == CREDITS) merr[NP+p] = 1'b1;
                    else mcrd[p]++;
                end else if (snd && !bus.flow_ctrl_in_op[p]) begin
                    mcrd[p]--;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            ebv[p]  = sbq[p].size() != 0;
            erdy[p] = mcrd[p] != 0;
        end
        chk("fc_out", 512'(bus.flow_ctrl_out_ip), 512'(efco));
        chk("buf_valid", 512'(bus.buf_valid), 512'(ebv));
        chk("core_ready", 512'(bus.core_ready), 512'(erdy));
        chk("chan_out", 512'(bus.channel_out_op), 512'(mout));
        chk("err_status", 512'(bus.error_status), 512'(merr));
        chk("error", 512'(bus.error), 512'(|merr));
    endtask

    task automatic push_flit(int p, logic [FW-1:0] f);
        bus.channel_in_ip[p*CH +: CH] = {1'b1, f};
    endtask

    initial begin
        int pulses;
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b1};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b1};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b1};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0};

        bus.channel_in_ip   = '0;
        bus.buf_ready       = '0;
        bus.core_flit       = '0;
        bus.core_valid      = '0;
        bus.flow_ctrl_in_op = '0;

        // Reset and idle
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        chk("rst_ready", 512'(bus.core_ready), 512'(5'h1f));
        chk("rst_bv", 512'(bus.buf_valid), 512'(0));
        chk("rst_err", 512'(bus.error), 512'(0));

        // Port 2 fill, overflow drop, drain
        for (int i = 1; i <= 5; i++) begin
            bus.channel_in_ip = '0;
            push_flit(2, FW'(i));
            cyc();
            if (i == 1) begin
                chk("p2_first_bv", 512'(bus.buf_valid[2]), 512'(1));
                chk("p2_first_flit", 512'(bus.buf_flit[2*FW +: FW]), 512'(1));
            end
        end
        chk("p2_ovf_err", 512'(bus.error_status[2]), 512'(1));
        chk("p2_ovf_error", 512'(bus.error), 512'(1));
        bus.channel_in_ip = '0;
        bus.buf_ready[2] = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            pulses += int'(bus.flow_ctrl_out_ip[2]);
        end
        bus.buf_ready[2] = 1'b0;
        chk("p2_pulses", 512'(pulses), 512'(4));

        // Port 0 full, push and pop together
        for (int i = 0; i < 4; i++) begin
            bus.channel_in_ip = '0;
            push_flit(0, FW'(8'h11 + i));
            cyc();
        end
        bus.channel_in_ip = '0;
        push_flit(0, FW'(9));
        bus.buf_ready[0] = 1'b1;
        cyc();
        bus.channel_in_ip = '0;
        chk("p0_no_err", 512'(bus.error_status[0]), 512'(0));
        for (int i = 0; i < 5; i++) cyc();
        bus.buf_ready[0] = 1'b0;

        // Port 1 credit table
        bus.core_flit[1*FW +: FW] = FW'(12'habc);
        for (int i = 0; i < 12; i++) begin
            bus.core_valid[1] = tbl[i].cv;
            bus.flow_ctrl_in_op[1] = tbl[i].fci;
            cyc();
            chk($sformatf("tbl_rdy_%0d", i),
                512'(bus.core_ready[1]), 512'(tbl[i].rdy));
            if (tbl[i].ov)
                chk($sformatf("tbl_out_%0d", i),
                    512'(bus.channel_out_op[1*CH +: CH]),
                    512'({1'b1, FW'(12'habc)}));
            else
                chk($sformatf("tbl_ov_%0d", i),
                    512'(bus.channel_out_op[1*CH+FW]), 512'(0));
        end
        bus.core_valid[1] = 1'b0;
        bus.flow_ctrl_in_op[1] = 1'b0;

        // Port 3 credit saturation, then send+credit at cnt=2
        bus.flow_ctrl_in_op[3] = 1'b1;
        cyc();
        bus.flow_ctrl_in_op[3] = 1'b0;
        chk("p3_covf", 512'(bus.error_status[8]), 512'(1));
        bus.core_flit[3*FW +: FW] = FW'(16'h3333);
        bus.core_valid[3] = 1'b1;
        cyc();
        cyc();
        bus.flow_ctrl_in_op[3] = 1'b1;
        cyc();
        bus.flow_ctrl_in_op[3] = 1'b0;
        cyc();
        chk("p3_rdy_1", 512'(bus.core_ready[3]), 512'(1));
        cyc();
        chk("p3_rdy_0", 512'(bus.core_ready[3]), 512'(0));
        bus.core_valid[3] = 1'b0;
        bus.flow_ctrl_in_op[3] = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        bus.flow_ctrl_in_op[3] = 1'b0;

        // Port 4 mid-stream reset
        bus.core_flit[4*FW +: FW] = FW'(8'h77);
        for (int i = 0; i < 3; i++) begin
            bus.channel_in_ip = '0;
            push_flit(4, FW'(8'h41 + i));
            bus.core_valid[4] = 1'b1;
            cyc();
        end
        bus.channel_in_ip = '0;
        bus.core_valid[4] = 1'b0;
        bus.buf_ready = '1;
        rst = 1'b1;
        cyc();
        chk("rst_bv4", 512'(bus.buf_valid[4]), 512'(0));
        chk("rst_errs", 512'(bus.error_status), 512'(0));
        chk("rst_fco", 512'(bus.flow_ctrl_out_ip), 512'(0));
        rst = 1'b0;
        bus.buf_ready = '0;
        cyc();
        chk("rst_fco2", 512'(bus.flow_ctrl_out_ip), 512'(0));
        bus.core_valid[4] = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        chk("p4_rdy_after3", 512'(bus.core_ready[4]), 512'(1));
        cyc();
        chk("p4_rdy_after4", 512'(bus.core_ready[4]), 512'(0));
        bus.core_valid[4] = 1'b0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
